// File: rtl/afu_wfifo_sync.sv
`default_nettype none
// ============================================================================
// Module  : afu_wfifo_sync
// Purpose : Single-clock AFU request FIFO with registered read data, registered
//           occupancy flags and sticky overflow/underflow reporting.
// Revision: 1.0 - initial release
// ============================================================================
module afu_wfifo_sync #(
  parameter int WIDTH           = 521,
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     aclr_n,
  input  logic [WIDTH-1:0]         data,
  input  logic                     wrreq,
  input  logic                     rdreq,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    usedw_q, usedw_d;
  logic [WIDTH-1:0] rdata_q;
  logic             valid_q;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_accept, rd_accept;

  // Flags are computed from the post-edge occupancy so they track usedw exactly.
  always_comb begin
    wr_accept = wrreq & ~full_q;
    rd_accept = rdreq & ~empty_q;
    usedw_d   = usedw_q;
    case ({wr_accept, rd_accept})
      2'b10:   usedw_d = usedw_q + C_ONE;
      2'b01:   usedw_d = usedw_q - C_ONE;
      default: usedw_d = usedw_q;
    endcase
    empty_d = (usedw_d == '0);
    full_d  = (usedw_d == C_DEPTH);
    afull_d = (usedw_d >= C_AFULL);
    ovf_d   = (ovf_q & ~err_clr) | (wrreq & full_q);
    unf_d   = (unf_q & ~err_clr) | (rdreq & empty_q);
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usedw_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_accept) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (rd_accept) begin
        rptr_q  <= rptr_q + AW'(1);
        rdata_q <= mem_q[rptr_q];
      end
      valid_q <= rd_accept;
      usedw_q <= usedw_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wptr_q] <= data;
    end
  end

  assign q           = rdata_q;
  assign q_valid     = valid_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign usedw       = usedw_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
`default_nettype wire

// File: doc/afu_wfifo_sync.md
Name: afu_wfifo_sync

Overview:
- Single-clock request/write-direction FIFO on the AFU side. It buffers 521-bit request flits from the AFU request generator toward the CXL link transmit path.
- It is the transmit-side counterpart of the AFU response FIFO: the same data/wrreq/rdreq/q/full/empty handshake, but multi-entry with occupancy and error reporting.
- Not FWFT: read data appears on q one cycle after an accepted rdreq.

Parameters:
- width, 521, flit width in bits.
- depth, 16, number of entries; power of two, minimum 2.
- almost_full_lvl, 12, usedw threshold at or above which almost_full asserts; must be between 1 and depth.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- aclr_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronous to clk by upstream logic.
- data  input  width  write flit.
- wrreq  input  1  write request; accepted only when full=0.
- rdreq  input  1  read request; accepted only when empty=0.
- err_clr  input  1  synchronous clear of the sticky overflow/underflow flags.
- q  output  width  read data, registered.
- q_valid  output  1  one-cycle pulse: q holds newly popped data.
- empty  output  1  no stored entries.
- full  output  1  usedw == depth.
- almost_full  output  1  usedw >= almost_full_lvl.
- usedw  output  clog2(depth)+1  occupancy, range 0..depth.
- overflow  output  1  sticky: a wrreq arrived while full.
- underflow  output  1  sticky: an rdreq arrived while empty.

Behaviour:
- Reset (aclr_n=0, asynchronous):
  - q=0, q_valid=0, empty=1, full=0, almost_full=0, usedw=0, overflow=0, underflow=0.
  - Read/write pointers go to 0. Storage contents are don't-care.
  - Reset mid-traffic discards all entries. The first read after reset returns only data written after reset.
- Storage: depth x width array. Write pointer and read pointer are each clog2(depth) bits and wrap modulo depth with no special case.
- Write accept, wa = wrreq & ~full (full sampled before the edge): mem[wptr] <= data; wptr increments.
- Read accept, ra = rdreq & ~empty: q <= mem[rptr]; rptr increments; q_valid <= 1.
  - Otherwise q_valid <= 0 and q holds its last value.
  - Read latency is 1 cycle from the accepting edge.
- Occupancy: usedw <= usedw + wa - ra. Simultaneous wa and ra leaves usedw unchanged.
- Flags are registered and derived from the next usedw, so they are valid in the same cycle as usedw:
  - empty = (usedw_next == 0)
  - full = (usedw_next == depth)
  - almost_full = (usedw_next >= almost_full_lvl)
- Boundary rules:
  - Full with wrreq=1 and rdreq=1: the read is accepted and the write is rejected (full was 1 before the edge). overflow sets; usedw becomes depth-1.
  - Empty with wrreq=1 and rdreq=1: the write is accepted and the read is rejected. underflow sets; usedw becomes 1; q_valid=0. No bypass from data to q.
  - Single entry with wrreq=1 and rdreq=1: both are accepted; usedw stays 1; q gets the old entry.
  - A rejected write or read does not modify pointers, storage, or q.
- Sticky error flags:
  - overflow <= overflow | (wrreq & full)
  - underflow <= underflow | (rdreq & empty)
  - err_clr=1 clears both flags. If a new error occurs in the same cycle as err_clr, the error wins and the flag stays 1.
- Ordering is strict FIFO. No data is lost except rejected writes.

Test Plan:
- Reset, then write 0x1, 0x2, 0x3 on consecutive cycles, then read 3 times:
  - q_valid pulses with q = 0x1, 0x2, 0x3, each one cycle after its rdreq.
  - usedw goes 1, 2, 3, 2, 1, 0; empty returns to 1 after the third read.
- Fill with 16 writes (values 0..15):
  - almost_full asserts when usedw reaches 12; full=1 at usedw=16.
  - A 17th wrreq sets overflow with usedw staying 16.
  - Draining returns 0..15 in order, with no trace of the rejected value.
- Wrap-around: stream 40 writes and 40 reads with occupancy held at 3–5. All 40 values return in order; no flags set.
- Simultaneous events:
  - When full, assert wrreq and rdreq together: usedw 16 -> 15, overflow=1, q = oldest entry.
  - When empty, assert both: usedw 0 -> 1, underflow=1, q_valid=0.
- Reset mid-operation: with usedw=7, pulse aclr_n low between clock edges.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Next write 0xAA followed by a read returns 0xAA.
- Set overflow, then pulse err_clr: overflow returns to 0. Repeat with err_clr held during a write to a full FIFO: overflow remains 1.
